lenet_layer_sequencer: RTL and testbench
========================================

// Module: lenet_layer_sequencer
//
// PURPOSE
// Top-level scheduler for the LeNet-5 datapath. On a start pulse it runs the three
// compute stages in order: L1 (conv1+pool), L3 (conv2+pool, the middle layer) and L5 (FC).
// Each stage gets a level enable and is held until it reports done. Enables are dropped
// and a settle gap is inserted between stages so each layer FSM can return to its IDLE state.
// A per-layer watchdog traps hung layers. The block sits between the host/test logic and the layer wrappers.
//
// PARAMETERS
// CNT_WIDTH      16     width of watchdog / per-layer cycle counter
// TIMEOUT_CYCLES 65535  cycles allowed in one RUN state before ERROR (< 2**CNT_WIDTH)
// GAP_CYCLES     2      minimum enable-low cycles between stages (>= 1)
// FRAME_WIDTH    8      width of completed-frame counter
//
// PORTS
// clk          in   1            clock, all logic on posedge
// rst          in   1            synchronous active-high reset
// start        in   1            request one frame; sampled only in IDLE
// abort        in   1            cancel frame in progress
// clear_err    in   1            leave ERROR state
// L1_done      in   1            layer-1 done (level, held while L1_en high)
// L3_done      in   1            layer-3 done (level, held while L3_en high)
// L5_done      in   1            layer-5 done (level, held while L5_en high)
// L1_en        out  1            layer-1 enable
// L3_en        out  1            layer-3 enable
// L5_en        out  1            layer-5 enable
// busy         out  1            high in any state except IDLE and ERROR
// frame_done   out  1            one-cycle pulse when L5 completes
// error        out  1            high in ERROR
// err_layer    out  2            01=L1, 10=L3, 11=L5 timed out; 00 otherwise
// frame_count  out  FRAME_WIDTH  completed frames, wraps to 0
// cycle_count  out  CNT_WIDTH    cycles spent in current RUN state
//
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0.
// - States: IDLE, RUN_L1, GAP_1, RUN_L3, GAP_3, RUN_L5, FINISH, ERROR.
// - IDLE: start=1 and abort=0 -> RUN_L1. Abort wins over a simultaneous start.
// - RUN_Lx: Lx_en=1 (registered, high the cycle after entry). cycle_count clears on entry and increments each cycle.
//   - Lx_done=1 -> GAP_x (L1->GAP_1, L3->GAP_3, L5->FINISH). Lx_en is low from the next cycle.
//   - Done inputs of layers not currently running are ignored.
// - Watchdog: cycle_count==TIMEOUT_CYCLES-1 with Lx_done=0 -> ERROR, and err_layer is latched.
//   Done wins if it arrives on the same cycle as the timeout.
// - GAP_x: all enables low. Leave only when GAP_CYCLES have elapsed AND the previous
//   layer's done has deasserted. Then GAP_1 -> RUN_L3 and GAP_3 -> RUN_L5.
// - FINISH: one cycle. frame_done=1 and frame_count+1 (wraps at 2**FRAME_WIDTH-1 -> 0); then -> IDLE.
// - abort=1 in any RUN or GAP state -> IDLE next cycle. Enables go low, no frame_done, frame_count unchanged.
// - ERROR: enables low, error=1, err_layer held. clear_err=1 -> IDLE with err_layer cleared. start is ignored while in ERROR.
// - busy=1 in RUN_*, GAP_* and FINISH states.
// - At most one of L1_en/L3_en/L5_en is high in any cycle.
// - rst asserted mid-frame returns to reset values next cycle, with no frame_done.
//
// TESTING  (GAP_CYCLES=2, TIMEOUT_CYCLES=16)
// 1 start at t0; each done 5 cycles after its enable rises and dropped 1 cycle after its enable falls
//   -> L1_en, L3_en, L5_en rise in turn, never overlap; frame_done pulses once; frame_count=1; busy low after.
// 2 L3_done never asserted -> at 16th RUN_L3 cycle: error=1, err_layer=10, L3_en=0;
//   clear_err -> IDLE, err_layer=00.
// 3 L1_done held high 4 cycles after L1_en falls -> RUN_L3 entry delayed until done low (GAP longer than 2).
// 4 abort during RUN_L3 -> L3_en low next cycle, state IDLE, no frame_done; start+abort same cycle in IDLE -> stays IDLE.
// 5 L5_done pulse during RUN_L1 -> ignored; Lx_done and timeout on same cycle -> advance, no error.
// 6 run 256 frames -> frame_count wraps to 0; rst asserted in GAP_1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lenet_layer_sequencer_if.sv
// Handshake bundle between the host/test logic and the LeNet layer sequencer:
// frame control in, per-layer enable/done pairs, and status/counter outputs.
interface lenet_layer_sequencer_if #(
    parameter int CNT_WIDTH   = 16,
    parameter int FRAME_WIDTH = 8
);
    logic                   start;
    logic                   abort;
    logic                   clear_err;
    logic                   L1_done;
    logic                   L3_done;
    logic                   L5_done;
    logic                   L1_en;
    logic                   L3_en;
    logic                   L5_en;
    logic                   busy;
    logic                   frame_done;
    logic                   error;
    logic [1:0]             err_layer;
    logic [FRAME_WIDTH-1:0] frame_count;
    logic [CNT_WIDTH-1:0]   cycle_count;

    modport master (
        output start, abort, clear_err, L1_done, L3_done, L5_done,
        input  L1_en, L3_en, L5_en, busy, frame_done, error, err_layer,
               frame_count, cycle_count
    );

    modport slave (
        input  start, abort, clear_err, L1_done, L3_done, L5_done,
        output L1_en, L3_en, L5_en, busy, frame_done, error, err_layer,
               frame_count, cycle_count
    );
endinterface

// File: rtl/lenet_layer_sequencer.sv
// Frame scheduler for the LeNet-5 datapath: runs L1, L3 and L5 in order with settle
// gaps between them, a per-layer watchdog, abort and an error trap.
module lenet_layer_sequencer #(
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_CYCLES     = 2,
    parameter int FRAME_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    lenet_layer_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_L1 = 3'd1,
        GAP_1  = 3'd2,
        RUN_L3 = 3'd3,
        GAP_3  = 3'd4,
        RUN_L5 = 3'd5,
        FINISH = 3'd6,
        ERROR  = 3'd7
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   GAP_LAST     = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [FRAME_WIDTH-1:0] FRAME_ONE    = FRAME_WIDTH'(1);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CNT_WIDTH-1:0]   cycle_count_r;
    logic [CNT_WIDTH-1:0]   gap_cnt_r;
    logic [FRAME_WIDTH-1:0] frame_count_r;
    logic [1:0]             err_layer_r;
    logic [1:0]             err_code_s;
    logic                   L1_en_r;
    logic                   L3_en_r;
    logic                   L5_en_r;
    logic                   busy_r;
    logic                   frame_done_r;
    logic                   error_r;
    logic                   timeout_s;
    logic                   gap_done_s;
    logic                   next_is_run_s;
    logic                   next_is_gap_s;

    // Next-state decode; abort outranks done, and done outranks the watchdog.
    always_comb begin
        state_next_s  = state_r;
        err_code_s    = 2'b00;
        timeout_s     = (cycle_count_r == TIMEOUT_LAST);
        gap_done_s    = (gap_cnt_r >= GAP_LAST);
        case (state_r)
            IDLE: begin
                if (bus.start && !bus.abort) state_next_s = RUN_L1;
                else                         state_next_s = IDLE;
            end
            RUN_L1: begin
                err_code_s = 2'b01;
                if (bus.abort)        state_next_s = IDLE;
                else if (bus.L1_done) state_next_s = GAP_1;
                else if (timeout_s)   state_next_s = ERROR;
                else                  state_next_s = RUN_L1;
            end
            GAP_1: begin
                if (bus.abort)                       state_next_s = IDLE;
                else if (gap_done_s && !bus.L1_done) state_next_s = RUN_L3;
                else                                 state_next_s = GAP_1;
            end
            RUN_L3: begin
                err_code_s = 2'b10;
                if (bus.abort)        state_next_s = IDLE;
                else if (bus.L3_done) state_next_s = GAP_3;
                else if (timeout_s)   state_next_s = ERROR;
                else                  state_next_s = RUN_L3;
            end
            GAP_3: begin
                if (bus.abort)                       state_next_s = IDLE;
                else if (gap_done_s && !bus.L3_done) state_next_s = RUN_L5;
                else                                 state_next_s = GAP_3;
            end
            RUN_L5: begin
                err_code_s = 2'b11;
                if (bus.abort)        state_next_s = IDLE;
                else if (bus.L5_done) state_next_s = FINISH;
                else if (timeout_s)   state_next_s = ERROR;
                else                  state_next_s = RUN_L5;
            end
            FINISH: begin
                state_next_s = IDLE;
            end
            ERROR: begin
                if (bus.clear_err) state_next_s = IDLE;
                else               state_next_s = ERROR;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign next_is_run_s = (state_next_s == RUN_L1) || (state_next_s == RUN_L3) ||
                           (state_next_s == RUN_L5);
    assign next_is_gap_s = (state_next_s == GAP_1) || (state_next_s == GAP_3);

    // State, counters and all outputs registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cycle_count_r <= {CNT_WIDTH{1'b0}};
            gap_cnt_r     <= {CNT_WIDTH{1'b0}};
            frame_count_r <= {FRAME_WIDTH{1'b0}};
            err_layer_r   <= 2'b00;
            L1_en_r       <= 1'b0;
            L3_en_r       <= 1'b0;
            L5_en_r       <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            L1_en_r      <= (state_next_s == RUN_L1);
            L3_en_r      <= (state_next_s == RUN_L3);
            L5_en_r      <= (state_next_s == RUN_L5);
            busy_r       <= (state_next_s != IDLE) && (state_next_s != ERROR);
            frame_done_r <= (state_next_s == FINISH);
            error_r      <= (state_next_s == ERROR);

            if (next_is_run_s && (state_next_s == state_r)) cycle_count_r <= cycle_count_r + CNT_ONE;
            else                                            cycle_count_r <= {CNT_WIDTH{1'b0}};

            // Gap counter saturates so a long-held done cannot wrap it.
            if (next_is_gap_s && (state_next_s == state_r) && (gap_cnt_r < GAP_LAST))
                gap_cnt_r <= gap_cnt_r + CNT_ONE;
            else if (next_is_gap_s && (state_next_s == state_r))
                gap_cnt_r <= gap_cnt_r;
            else
                gap_cnt_r <= {CNT_WIDTH{1'b0}};

            if (state_next_s == FINISH) frame_count_r <= frame_count_r + FRAME_ONE;
            else                        frame_count_r <= frame_count_r;

            if ((state_next_s == ERROR) && (state_r != ERROR)) err_layer_r <= err_code_s;
            else if (state_next_s == ERROR)                    err_layer_r <= err_layer_r;
            else                                               err_layer_r <= 2'b00;
        end
    end

    assign bus.L1_en       = L1_en_r;
    assign bus.L3_en       = L3_en_r;
    assign bus.L5_en       = L5_en_r;
    assign bus.busy        = busy_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.error       = error_r;
    assign bus.err_layer   = err_layer_r;
    assign bus.frame_count = frame_count_r;
    assign bus.cycle_count = cycle_count_r;

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Directed bench for lenet_layer_sequencer with GAP_CYCLES=2 and TIMEOUT_CYCLES=16;
// a scripted layer responder drives the done inputs and expected values are hand-derived.
module tb_lenet_layer_sequencer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   exp_frames;
    int   pulse_cnt;
    int   overlap_cnt;

    lenet_layer_sequencer_if #(.CNT_WIDTH(16), .FRAME_WIDTH(8)) bus ();

    lenet_layer_sequencer #(
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (16),
        .GAP_CYCLES     (2),
        .FRAME_WIDTH    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_done cycles and any cycle with more than one enable high.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if ((int'(bus.L1_en) + int'(bus.L3_en) + int'(bus.L5_en)) > 1) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic en_of(input int n);
        case (n)
            1:       return bus.L1_en;
            3:       return bus.L3_en;
            default: return bus.L5_en;
        endcase
    endfunction

    task automatic set_done(input int n, input logic v);
        case (n)
            1:       bus.L1_done = v;
            3:       bus.L3_done = v;
            default: bus.L5_done = v;
        endcase
    endtask

    task automatic wait_en(input int n);
        for (int i = 0; i < 50 && en_of(n) !== 1'b1; i++) tick();
        check_eq("wait_en", en_of(n), 1);
    endtask

    // Responder: done rises lat cycles after enable, falls hold cycles after enable drops.
    task automatic drive_layer(input int n, input int lat, input int hold);
        wait_en(n);
        check_eq("cyc_entry", bus.cycle_count, 0);
        repeat (lat) tick();
        check_eq("cyc_run", bus.cycle_count, lat);
        set_done(n, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (en_of(n) !== 1'b1) break;
        end
        check_eq("en_fall", en_of(n), 0);
        repeat (hold) tick();
        set_done(n, 1'b0);
    endtask

    task automatic run_frame(input int lat, input int hold);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drive_layer(1, lat, hold);
        drive_layer(3, lat, hold);
        drive_layer(5, lat, hold);
        tick();
        exp_frames++;
    endtask

    initial begin
        errors = 0; checks = 0; exp_frames = 0; pulse_cnt = 0; overlap_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.clear_err = 1'b0;
        bus.L1_done = 1'b0; bus.L3_done = 1'b0; bus.L5_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_en", {bus.L1_en, bus.L3_en, bus.L5_en}, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_err", {bus.error, bus.err_layer, bus.frame_done}, 0);
        check_eq("rst_cnt", {bus.frame_count, bus.cycle_count}, 0);

        // 1: nominal frame
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("t1_l1_en", bus.L1_en, 1);
        check_eq("t1_busy", bus.busy, 1);
        drive_layer(1, 5, 1);
        drive_layer(3, 5, 1);
        drive_layer(5, 5, 1);
        tick();
        exp_frames++;
        check_eq("t1_frames", bus.frame_count, 1);
        check_eq("t1_pulses", pulse_cnt, 1);
        check_eq("t1_busy_after", bus.busy, 0);

        // 2: L3 hangs -> watchdog
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drive_layer(1, 5, 1);
        wait_en(3);
        repeat (15) tick();
        check_eq("t2_cyc15", bus.cycle_count, 15);
        check_eq("t2_pre_err", {bus.L3_en, bus.error}, 2'b10);
        tick();
        check_eq("t2_error", bus.error, 1);
        check_eq("t2_err_layer", bus.err_layer, 2'b10);
        check_eq("t2_en_low", {bus.L1_en, bus.L3_en, bus.L5_en, bus.busy}, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("t2_start_ign", {bus.error, bus.L1_en, bus.busy}, 3'b100);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        check_eq("t2_cleared", {bus.error, bus.err_layer, bus.busy}, 0);

        // 3: L1 done held 4 cycles past enable fall stretches GAP_1
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drive_layer(1, 5, 4);
        check_eq("t3_gap_held", {bus.L3_en, bus.busy}, 2'b01);
        tick();
        check_eq("t3_l3_en", bus.L3_en, 1);
        drive_layer(3, 5, 1);
        drive_layer(5, 5, 1);
        tick();
        exp_frames++;
        check_eq("t3_frames", bus.frame_count, exp_frames);

        // 4: abort in RUN_L3, then start+abort in IDLE
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drive_layer(1, 2, 1);
        wait_en(3);
        tick(); tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("t4_abort", {bus.L3_en, bus.busy, bus.frame_done}, 0);
        check_eq("t4_frames", bus.frame_count, exp_frames);
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check_eq("t4_start_abort", {bus.L1_en, bus.busy}, 0);
        check_eq("t4_pulses", pulse_cnt, exp_frames);

        // 5: stray L5_done ignored; done on the timeout cycle advances
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.L5_done = 1'b1;
        tick();
        bus.L5_done = 1'b0;
        tick();
        check_eq("t5_stray", {bus.L1_en, bus.L5_en, bus.busy}, 3'b101);
        for (int i = 0; i < 40 && bus.cycle_count != 16'd15; i++) tick();
        check_eq("t5_cyc15", bus.cycle_count, 15);
        bus.L1_done = 1'b1;
        tick();
        check_eq("t5_done_wins", {bus.error, bus.L1_en, bus.busy}, 3'b001);
        tick();
        bus.L1_done = 1'b0;
        drive_layer(3, 1, 1);
        drive_layer(5, 1, 1);
        tick();
        exp_frames++;
        check_eq("t5_frames", bus.frame_count, exp_frames);

        // 6: frame counter wrap, then reset in GAP_1
        while (exp_frames < 255) run_frame(0, 0);
        check_eq("t6_255", bus.frame_count, 255);
        run_frame(0, 0);
        check_eq("t6_wrap", bus.frame_count, 0);
        check_eq("t6_pulses", pulse_cnt, exp_frames);
        run_frame(0, 0);
        check_eq("t6_one", bus.frame_count, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drive_layer(1, 0, 0);
        check_eq("t6_in_gap", {bus.busy, bus.L1_en, bus.L3_en}, 3'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_rst_en", {bus.L1_en, bus.L3_en, bus.L5_en, bus.busy}, 0);
        check_eq("t6_rst_stat", {bus.frame_done, bus.error, bus.err_layer}, 0);
        check_eq("t6_rst_cnt", {bus.frame_count, bus.cycle_count}, 0);
        check_eq("overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
